// File: rtl/digital_port_irq.sv
`default_nettype none
// ============================================================================
//  Module      : digital_port_irq
//  Description : Parametrised GPIO port with per-pin direction, atomic
//                SET/CLR/TGL output updates, synchronised inputs and sticky
//                W1C edge-interrupt status driving one level irq line.
//                Optional input debounce when DIGITAL_PORT_DEBOUNCE_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module digital_port_irq #(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chipSelect,
    input  logic             writeEnable,
    input  logic [2:0]       address,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             irq,
    inout  wire  [WIDTH-1:0] IO
);

    localparam logic [2:0] c_ADDR_VALUE  = 3'd0;
    localparam logic [2:0] c_ADDR_DIR    = 3'd1;
    localparam logic [2:0] c_ADDR_SET    = 3'd2;
    localparam logic [2:0] c_ADDR_CLR    = 3'd3;
    localparam logic [2:0] c_ADDR_TGL    = 3'd4;
    localparam logic [2:0] c_ADDR_RISE   = 3'd5;
    localparam logic [2:0] c_ADDR_FALL   = 3'd6;
    localparam logic [2:0] c_ADDR_STATUS = 3'd7;

    if ((WIDTH < 1) || (WIDTH > 32) || (SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 2)) begin : g_paramCheck
        $error("digital_port_irq: illegal parameter value");
    end

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_riseEn;
    logic [WIDTH-1:0] r_fallEn;
    logic [WIDTH-1:0] r_status;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic             r_irq;

    logic             w_wr;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_syncd;
    logic [WIDTH-1:0] w_cond;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    assign w_wr  = chipSelect & writeEnable;
    assign w_w1c = (w_wr && (address == c_ADDR_STATUS)) ? dataIn : '0;

    // Pin drivers: undriven pins float so the external world sets their level
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign IO[i] = r_dir[i] ? r_out[i] : 1'bz;
    end

    // ------------------------------------------------------------------------
    // Bus register writes
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out    <= '0;
            r_dir    <= '0;
            r_riseEn <= '0;
            r_fallEn <= '0;
        end else if (w_wr) begin
            case (address)
                c_ADDR_VALUE: r_out    <= dataIn;
                c_ADDR_DIR:   r_dir    <= dataIn;
                c_ADDR_SET:   r_out    <= r_out | dataIn;
                c_ADDR_CLR:   r_out    <= r_out & ~dataIn;
                c_ADDR_TGL:   r_out    <= r_out ^ dataIn;
                c_ADDR_RISE:  r_riseEn <= dataIn;
                c_ADDR_FALL:  r_fallEn <= dataIn;
                default:      ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Input synchroniser chain
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= IO;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_syncd = r_sync[SYNC_STAGES-1];

`ifdef DIGITAL_PORT_DEBOUNCE_EN
    localparam int                  c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    // A pin level is accepted only after it differs from the debounced value
    // for DEBOUNCE_CYCLES consecutive samples; any return resets the count.
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_debounced;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt       <= '0;
                r_debounced <= 1'b0;
            end else if (w_syncd[i] == r_debounced) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_debounced <= w_syncd[i];
                r_cnt       <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_cond[i] = r_debounced;
    end
`else
    assign w_cond = w_syncd;
`endif

    // ------------------------------------------------------------------------
    // Edge detection, sticky status and interrupt
    // ------------------------------------------------------------------------
    assign w_rise = w_cond & ~r_prev;
    assign w_fall = ~w_cond & r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev   <= '0;
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_prev   <= w_cond;
            // Set terms are ORed after the clear so a coincident edge wins
            r_status <= (r_status & ~w_w1c) | (w_rise & r_riseEn) | (w_fall & r_fallEn);
            r_irq    <= |r_status;
        end
    end

    assign irq = r_irq;

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    always_comb begin
        dataOut = '0;
        case (address)
            c_ADDR_VALUE:  dataOut = w_cond;
            c_ADDR_DIR:    dataOut = r_dir;
            c_ADDR_SET,
            c_ADDR_CLR,
            c_ADDR_TGL:    dataOut = r_out;
            c_ADDR_RISE:   dataOut = r_riseEn;
            c_ADDR_FALL:   dataOut = r_fallEn;
            c_ADDR_STATUS: dataOut = r_status;
            default:       dataOut = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_digital_port_irq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digital_port_irq
//  Description : Directed self-checking bench for digital_port_irq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digital_port_irq;

`ifdef DIGITAL_PORT_DEBOUNCE_EN
    localparam int CL = 2 + 4;
`else
    localparam int CL = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        chipSelect;
    logic        writeEnable;
    logic [2:0]  address;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        irq;
    wire  [31:0] io;

    logic [31:0] tbEn;
    logic [31:0] tbVal;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 32; i++) begin : g_drv
        assign io[i] = tbEn[i] ? tbVal[i] : 1'bz;
    end

    digital_port_irq #(
        .WIDTH          (32),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .chipSelect (chipSelect),
        .writeEnable(writeEnable),
        .address    (address),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .irq        (irq),
        .IO         (io)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipSelect  = 1'b1;
        writeEnable = 1'b1;
        address     = a;
        dataIn      = d;
        tick(1);
        chipSelect  = 1'b0;
        writeEnable = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        #1;
    endtask

    initial begin
        rst = 1'b0; chipSelect = 1'b0; writeEnable = 1'b0;
        address = 3'd0; dataIn = '0;
        tbEn = 32'hFFFF_FF00; tbVal = '0;

        // Reset state
        #1;
        check("rst_irq", {31'b0, irq}, 32'h0);
        rd(3'd1); check("rst_dir", dataOut, 32'h0);
        rd(3'd7); check("rst_status", dataOut, 32'h0);
        #20;
        rst = 1'b1;
        tick(1);

        // Drive / readback
        wr(3'd1, 32'h0000_00FF);
        wr(3'd0, 32'h0000_00A5);
        check("drive_io", {24'b0, io[7:0]}, 32'hA5);
        tick(CL - 1);
        rd(3'd0); check("value_early", dataOut, 32'h0);
        tick(1);
        rd(3'd0); check("value_readback", dataOut, 32'h0000_00A5);

        // Undriven upper pins follow the external level, not the latch
        wr(3'd0, 32'hFFFF_FFA5);
        tbVal = 32'h5A5A_5A00;
        tick(CL);
        rd(3'd0); check("value_upper_z", dataOut, 32'h5A5A_5AA5);
        rd(3'd2); check("latch_full", dataOut, 32'hFFFF_FFA5);

        // Atomic ops
        wr(3'd0, 32'h0000_000F);
        wr(3'd2, 32'h0000_0030);
        rd(3'd2); check("set", dataOut, 32'h0000_003F);
        wr(3'd3, 32'h0000_0003);
        rd(3'd3); check("clr", dataOut, 32'h0000_003C);
        wr(3'd4, 32'h0000_00FF);
        rd(3'd4); check("tgl", dataOut, 32'h0000_00C3);
        check("tgl_io", {24'b0, io[7:0]}, 32'hC3);

        // Write without chipSelect is ignored
        writeEnable = 1'b1; address = 3'd1; dataIn = 32'hFFFF_FFFF;
        tick(1);
        writeEnable = 1'b0;
        rd(3'd1); check("no_cs_write", dataOut, 32'h0000_00FF);

        // Hand all pins to the bench
        wr(3'd1, 32'h0);
        tbEn = 32'hFFFF_FFFF; tbVal = 32'h0;
        tick(CL + 2);
        rd(3'd7); check("status_quiet", dataOut, 32'h0);

        // Rising edge latency
        wr(3'd5, 32'h1);
        tbVal[0] = 1'b1;
        tick(CL);
        rd(3'd7); check("rise_early", dataOut, 32'h0);
        tick(1);
        rd(3'd7); check("rise_status", dataOut, 32'h1);
        check("rise_irq_early", {31'b0, irq}, 32'h0);
        tick(1);
        check("rise_irq", {31'b0, irq}, 32'h1);

        // Disabling an enable keeps status
        wr(3'd5, 32'h0);
        rd(3'd7); check("en_clear_keeps", dataOut, 32'h1);
        wr(3'd5, 32'h1);

        // Quiet W1C
        wr(3'd7, 32'h1);
        rd(3'd7); check("w1c_quiet", dataOut, 32'h0);
        check("w1c_irq_hold", {31'b0, irq}, 32'h1);
        tick(1);
        check("w1c_irq_drop", {31'b0, irq}, 32'h0);

        // Fall with FALL_EN=0
        tbVal[0] = 1'b0;
        tick(CL + 2);
        rd(3'd7); check("fall_disabled", dataOut, 32'h0);

        // W1C colliding with a new rise: set wins
        tbVal[0] = 1'b1;
        tick(CL + 1);
        rd(3'd7); check("rise_again", dataOut, 32'h1);
        tbVal[0] = 1'b0;
        tick(CL + 2);
        tbVal[0] = 1'b1;
        tick(CL);
        wr(3'd7, 32'h1);
        rd(3'd7); check("w1c_collision", dataOut, 32'h1);
        tick(2);
        wr(3'd7, 32'h1);
        rd(3'd7); check("w1c_after", dataOut, 32'h0);
        tick(1);
        check("w1c_after_irq", {31'b0, irq}, 32'h0);

        // Falling edge on pin 1 with FALL_EN
        wr(3'd6, 32'h2);
        tbVal[1] = 1'b1;
        tick(CL + 2);
        rd(3'd7); check("rise1_disabled", dataOut, 32'h0);
        tbVal[1] = 1'b0;
        tick(CL + 1);
        rd(3'd7); check("fall1_status", dataOut, 32'h2);

`ifdef DIGITAL_PORT_DEBOUNCE_EN
        // Debounce: short pulse invisible, held level accepted
        wr(3'd5, 32'h5);
        tbVal[2] = 1'b1;
        tick(3);
        tbVal[2] = 1'b0;
        tick(10);
        rd(3'd0); check("deb_glitch_val", {31'b0, dataOut[2]}, 32'h0);
        rd(3'd7); check("deb_glitch_st", dataOut, 32'h2);
        tbVal[2] = 1'b1;
        tick(5);
        rd(3'd0); check("deb_hold_early", {31'b0, dataOut[2]}, 32'h0);
        tick(1);
        rd(3'd0); check("deb_hold_val", {31'b0, dataOut[2]}, 32'h1);
        rd(3'd7); check("deb_hold_st0", dataOut, 32'h2);
        tick(1);
        rd(3'd7); check("deb_hold_st1", dataOut, 32'h6);
`endif

        // Build STATUS=0x3 with irq high
        wr(3'd7, 32'hFFFF_FFFF);
        tbVal[1:0] = 2'b10;
        tick(CL + 2);
        rd(3'd7); check("pre_reset_quiet", dataOut, 32'h0);
        tbVal[1:0] = 2'b01;
        tick(CL + 2);
        rd(3'd7); check("pre_reset_status", dataOut, 32'h3);
        check("pre_reset_irq", {31'b0, irq}, 32'h1);

        // Async reset between edges
        tbEn = 32'h0;
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'hFFFF_FFFF);
        #2;
        rst = 1'b0;
        #1;
        check("async_irq", {31'b0, irq}, 32'h0);
        rd(3'd7); check("async_status", dataOut, 32'h0);
        rd(3'd1); check("async_dir", dataOut, 32'h0);
        tbEn = 32'hFFFF_FFFF; tbVal = 32'h1234_5678;
        #1;
        check("async_io_z", io, 32'h1234_5678);
        rst = 1'b1;
        tick(CL + 3);
        rd(3'd7); check("post_reset_status", dataOut, 32'h0);
        rd(3'd0); check("post_reset_value", dataOut, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digital_port_irq.md
Name: digital_port_irq

Overview:
- Parametrised GPIO port; successor to the fixed 32-bit digital port, sitting on the CPU peripheral bus.
- Per-pin direction and output latch, with atomic SET/CLEAR/TOGGLE writes.
- Synchronised pin inputs with per-pin rising/falling-edge detection and sticky W1C interrupt status.
- One level interrupt line to the interrupt controller.

Parameters:
WIDTH, 32, number of pins (1..32)
SYNC_STAGES, 2, input synchroniser depth (>=2)
DEBOUNCE_CYCLES, 16, stable-sample count when DIGITAL_PORT_DEBOUNCE_EN is defined (>=2)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
chipSelect  input  1  bus access strobe
writeEnable  input  1  write qualifier, valid with chipSelect
address  input  3  register select
dataIn  input  WIDTH  write data
dataOut  output  WIDTH  read data, combinational from address
irq  output  1  registered interrupt request
IO  inout  WIDTH  FPGA pins

Behaviour:
- Register map (address → name):
  - 0 VALUE: read = conditioned pin value; write = output latch.
  - 1 DIR: 1 = drive.
  - 2 SET: out |= dataIn.
  - 3 CLR: out &= ~dataIn.
  - 4 TGL: out ^= dataIn.
  - 5 RISE_EN.
  - 6 FALL_EN.
  - 7 STATUS: read sticky flags; write-1-to-clear.
- Reads of 2/3/4 return the output latch.
- Writes take effect on the rising clk edge with chipSelect=1 and writeEnable=1; otherwise ignored.
- Pins: IO[i] = DIR[i] ? out[i] : Z. Driven pins read back through the same input path.
- Input path:
  - Chain of SYNC_STAGES flops per pin; the last stage is "syncd".
  - Without debounce, conditioned value = syncd.
  - prev <= conditioned value each cycle.
  - rise = cond & ~prev; fall = ~cond & prev.
- STATUS next = (STATUS & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - An edge and a W1C on the same bit in the same cycle: set wins.
  - Enable bits are sampled in the same cycle as the edge.
  - Clearing an enable does not clear STATUS.
- irq <= |STATUS (registered; one cycle after STATUS sets or clears).
- Latency (no debounce), counting clk edges after the pin changes:
  - VALUE read reflects the change after SYNC_STAGES edges.
  - STATUS sets at SYNC_STAGES+1.
  - irq asserts at SYNC_STAGES+2.
- Reset, async on rst falling (including mid-operation):
  - DIR, out, RISE_EN, FALL_EN, STATUS, sync chain, prev and irq all go to 0.
  - All pins go high-Z immediately.
  - Edges produced by the chain filling after reset release cannot set STATUS, because enables are 0.
- Bits above WIDTH do not exist; the bus master zero-extends.
- No FSM beyond per-pin shift/compare state (plus debounce counters when enabled).

Optional Feature:
- Macro: DIGITAL_PORT_DEBOUNCE_EN.
- Defined:
  - Each pin has a counter of width $clog2(DEBOUNCE_CYCLES+1) and a debounced register (reset 0).
  - The counter clears whenever syncd equals debounced; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1, debounced <= syncd and the counter clears.
  - Conditioned value = debounced. Glitches shorter than DEBOUNCE_CYCLES cycles are invisible.
  - Latency from the pin change to a VALUE update grows by DEBOUNCE_CYCLES edges.
- Undefined: no counters; conditioned value = syncd.

Test Plan:
- Drive/readback: reset; write DIR=0x0000_00FF, VALUE=0x0000_00A5 → IO[7:0]=0xA5, IO[31:8]=Z. After 2 edges, VALUE reads 0x0000_00A5 when the external pull on IO[31:8] is 0.
- Atomic ops: out=0x0F; SET 0x30 → 0x3F; CLR 0x03 → 0x3C; TGL 0xFF → 0xC3. Reads of addresses 2/3/4 return the latch.
- Rising edge: RISE_EN=0x1; IO[0] 0→1 at edge 0 → STATUS=0x1 at edge 3, irq=1 at edge 4. FALL_EN=0 with a 1→0 transition → no status.
- W1C collision: STATUS[0]=1; write STATUS=0x1 in the same cycle a new rise on pin 0 is detected → STATUS[0] stays 1. W1C on a quiet cycle → 0; irq drops next cycle.
- Async reset mid-operation: DIR=0xFFFF_FFFF, STATUS=0x3, irq=1; pull rst low between clk edges → IO all Z, dataOut for STATUS=0, irq=0 without a clock edge.
- Debounce (macro defined, DEBOUNCE_CYCLES=4): a 3-cycle high pulse on IO[1] → no VALUE change, no STATUS. A held level → VALUE[1]=1 after 2+4 edges; STATUS[1] sets one edge later.
